// File: rtl/idli_srf_m_if.sv
// Transfer request and serial data bundle for the idli bit-serial register file.
// Handshake: i_srf_start is a request accepted whenever o_srf_busy is 0 or o_srf_last is 1
// (the acceptance acts as ready); index/enable fields are captured only on an accepted start.
interface idli_srf_m_if #(
   parameter int IDXW  = 2,
   parameter int BEATW = 4
);
   logic             i_srf_start;
   logic [IDXW-1:0]  i_srf_p;
   logic [IDXW-1:0]  i_srf_q;
   logic             i_srf_wr_en;
   logic [IDXW-1:0]  i_srf_wr_idx;
   logic             i_srf_wr_data;
   logic             o_srf_p_data;
   logic             o_srf_q_data;
   logic             o_srf_busy;
   logic [BEATW-1:0] o_srf_beat;
   logic             o_srf_last;
   logic             o_srf_state;

   modport master (
      output i_srf_start, i_srf_p, i_srf_q, i_srf_wr_en, i_srf_wr_idx, i_srf_wr_data,
      input  o_srf_p_data, o_srf_q_data, o_srf_busy, o_srf_beat, o_srf_last, o_srf_state
   );

   modport slave (
      input  i_srf_start, i_srf_p, i_srf_q, i_srf_wr_en, i_srf_wr_idx, i_srf_wr_data,
      output o_srf_p_data, o_srf_q_data, o_srf_busy, o_srf_beat, o_srf_last, o_srf_state
   );
endinterface

// File: rtl/idli_srf_m.sv
// Bit-serial register file: NUM_REGS writable registers plus a constant register,
// two LSB-first read ports and one write port streamed over WIDTH beats.
module idli_srf_m #(
   parameter int              NUM_REGS  = 3,
   parameter int              WIDTH     = 16,
   parameter logic [WIDTH-1:0] CONST_VAL = '1
) (
   input logic          i_srf_gck,
   input logic          i_srf_rst_n,
   idli_srf_m_if.slave  srf
);
   localparam int IDXW = $clog2(NUM_REGS + 1);
   localparam int BW   = $clog2(WIDTH);
   localparam logic [IDXW-1:0] CONST_IDX = IDXW'(NUM_REGS);
   localparam logic [BW-1:0]   LAST_BEAT = BW'(WIDTH - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_e;

   state_e          state_q, state_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [IDXW-1:0] p_q, p_d, q_q, q_d, wi_q, wi_d;
   logic            we_q, we_d;
   logic [WIDTH-1:0] regs_q [NUM_REGS];
   logic            busy, last, accept;

   assign busy   = (state_q == ST_ACTIVE);
   assign last   = busy && (beat_q == LAST_BEAT);
   assign accept = srf.i_srf_start && (!busy || last);

   always_ff @(posedge i_srf_gck or negedge i_srf_rst_n) begin
      if (!i_srf_rst_n) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         p_q     <= '0;
         q_q     <= '0;
         wi_q    <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         p_q     <= p_d;
         q_q     <= q_d;
         wi_q    <= wi_d;
         we_q    <= we_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      p_d     = p_q;
      q_d     = q_q;
      wi_d    = wi_q;
      we_d    = we_q;
      case (state_q)
         ST_IDLE: begin
            beat_d = '0;
            if (accept) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (last) begin
               beat_d = '0;
               if (!accept) state_d = ST_IDLE;
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (accept) begin
         p_d  = srf.i_srf_p;
         q_d  = srf.i_srf_q;
         wi_d = srf.i_srf_wr_idx;
         we_d = srf.i_srf_wr_en;
      end
   end

   // The write lands on the edge that ends the beat, so a same-beat read still sees the old bit.
   always_ff @(posedge i_srf_gck or negedge i_srf_rst_n) begin
      if (!i_srf_rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (busy && we_q && (wi_q < CONST_IDX)) begin
         regs_q[wi_q][beat_q] <= srf.i_srf_wr_data;
      end
   end

   function automatic logic rd_bit(input logic [IDXW-1:0] idx, input logic [BW-1:0] bt);
      logic b;
      b = 1'b0;
      if (idx < CONST_IDX)       b = regs_q[idx][bt];
      else if (idx == CONST_IDX) b = CONST_VAL[bt];
      return b;
   endfunction

   always_comb begin
      srf.o_srf_p_data = 1'b0;
      srf.o_srf_q_data = 1'b0;
      if (busy) begin
         srf.o_srf_p_data = rd_bit(p_q, beat_q);
         srf.o_srf_q_data = rd_bit(q_q, beat_q);
      end
   end

   assign srf.o_srf_busy  = busy;
   assign srf.o_srf_beat  = beat_q;
   assign srf.o_srf_last  = last;
   assign srf.o_srf_state = state_q;
endmodule

// File: tb/tb_idli_srf_m.sv
// Directed bench for idli_srf_m: a register/transfer model checked every cycle,
// plus hand-computed word-level expectations.
module tb_idli_srf_m;
  logic clk;
  logic rst_n;
  int n_checks;
  int n_fail;
  bit chk_en;

  idli_srf_m_if #(.IDXW(2), .BEATW(4)) a_if ();
  idli_srf_m_if #(.IDXW(3), .BEATW(3)) b_if ();

  idli_srf_m u_dut_a (.i_srf_gck(clk), .i_srf_rst_n(rst_n), .srf(a_if.slave));
  idli_srf_m #(.NUM_REGS(5), .WIDTH(8)) u_dut_b (.i_srf_gck(clk), .i_srf_rst_n(rst_n), .srf(b_if.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, got running want done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model of the 3 x 16 file
  logic [15:0] m_regs [3];
  bit m_busy;
  int m_beat;
  int m_p, m_q, m_wi;
  bit m_we;
  logic [15:0] exp_q [$];

  function automatic logic m_rd(input int idx, input int bt);
    if (idx < 3) return m_regs[idx][bt];
    if (idx == 3) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m_regs[i] = '0;
      m_busy = 0; m_beat = 0; m_p = 0; m_q = 0; m_wi = 0; m_we = 0;
    end else begin
      if (m_busy && m_we && m_wi < 3) m_regs[m_wi][m_beat] = a_if.i_srf_wr_data;
      if (!m_busy || m_beat == 15) begin
        m_beat = 0;
        m_busy = a_if.i_srf_start;
        if (a_if.i_srf_start) begin
          m_p = a_if.i_srf_p; m_q = a_if.i_srf_q;
          m_we = a_if.i_srf_wr_en; m_wi = a_if.i_srf_wr_idx;
        end
      end else begin
        m_beat = m_beat + 1;
      end
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(a_if.o_srf_busy), 32'(m_busy));
      chk("state", 32'(a_if.o_srf_state), 32'(m_busy));
      chk("beat", 32'(a_if.o_srf_beat), 32'(m_beat));
      chk("last", 32'(a_if.o_srf_last), 32'(m_busy && m_beat == 15));
      chk("p_data", 32'(a_if.o_srf_p_data), 32'(m_busy ? m_rd(m_p, m_beat) : 1'b0));
      chk("q_data", 32'(a_if.o_srf_q_data), 32'(m_busy ? m_rd(m_q, m_beat) : 1'b0));
    end
  end

  // driver tasks
  task automatic xfer(input int p, input int q, input bit we, input int wi,
                      input logic [15:0] data, output logic [15:0] pw, output logic [15:0] qw);
    @(negedge clk);
    a_if.i_srf_start = 1'b1; a_if.i_srf_p = 2'(p); a_if.i_srf_q = 2'(q);
    a_if.i_srf_wr_en = we; a_if.i_srf_wr_idx = 2'(wi);
    @(negedge clk);
    a_if.i_srf_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a_if.i_srf_wr_data = data[k];
      pw[k] = a_if.o_srf_p_data;
      qw[k] = a_if.o_srf_q_data;
      @(negedge clk);
    end
    a_if.i_srf_wr_en = 1'b0;
  endtask

  task automatic xfer_b(input int p, input int q, input bit we, input int wi,
                        input logic [7:0] data, output logic [7:0] pw, output logic [7:0] qw);
    @(negedge clk);
    b_if.i_srf_start = 1'b1; b_if.i_srf_p = 3'(p); b_if.i_srf_q = 3'(q);
    b_if.i_srf_wr_en = we; b_if.i_srf_wr_idx = 3'(wi);
    @(negedge clk);
    b_if.i_srf_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      b_if.i_srf_wr_data = data[k];
      pw[k] = b_if.o_srf_p_data;
      qw[k] = b_if.o_srf_q_data;
      chk("b_busy", 32'(b_if.o_srf_busy), 32'd1);
      chk("b_beat", 32'(b_if.o_srf_beat), 32'(k));
      @(negedge clk);
    end
    b_if.i_srf_wr_en = 1'b0;
    chk("b_idle", 32'(b_if.o_srf_busy), 32'd0);
  endtask

  logic [15:0] pw, qw;
  logic [7:0] pb, qb;

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 0;
    rst_n = 1'b0;
    a_if.i_srf_start = 0; a_if.i_srf_p = 0; a_if.i_srf_q = 0;
    a_if.i_srf_wr_en = 0; a_if.i_srf_wr_idx = 0; a_if.i_srf_wr_data = 0;
    b_if.i_srf_start = 0; b_if.i_srf_p = 0; b_if.i_srf_q = 0;
    b_if.i_srf_wr_en = 0; b_if.i_srf_wr_idx = 0; b_if.i_srf_wr_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(a_if.o_srf_busy), 32'd0);
    chk("rst_beat", 32'(a_if.o_srf_beat), 32'd0);
    chk("rst_p", 32'(a_if.o_srf_p_data), 32'd0);
    #1 rst_n = 1'b1;
    chk_en = 1;

    // defaults: p=r0, q=constant
    xfer(0, 3, 0, 0, 16'h0000, pw, qw);
    chk("dflt_p", 32'(pw), 32'h0000);
    chk("dflt_q", 32'(qw), 32'hFFFF);
    chk("dflt_idle", 32'(a_if.o_srf_busy), 32'd0);

    // write r1 then read it back; r0/r2 untouched
    xfer(0, 0, 1, 1, 16'hA5C3, pw, qw);
    exp_q.push_back(16'hA5C3);
    xfer(1, 0, 0, 0, 16'h0000, pw, qw);
    chk("r1_read", 32'(pw), 32'(exp_q.pop_front()));
    chk("r0_read", 32'(qw), 32'h0000);
    xfer(2, 2, 0, 0, 16'h0000, pw, qw);
    chk("r2_read", 32'(pw), 32'h0000);

    // in-place increment of r2
    xfer(0, 0, 1, 2, 16'h00FF, pw, qw);
    xfer(2, 2, 1, 2, 16'h0100, pw, qw);
    chk("inc_old_p", 32'(pw), 32'h00FF);
    chk("inc_old_q", 32'(qw), 32'h00FF);
    xfer(2, 1, 0, 0, 16'h0000, pw, qw);
    chk("inc_new", 32'(pw), 32'h0100);
    chk("inc_r1", 32'(qw), 32'hA5C3);

    // back-to-back with ignored mid-transfer start pulses
    @(negedge clk);
    a_if.i_srf_start = 1; a_if.i_srf_p = 0; a_if.i_srf_q = 0; a_if.i_srf_wr_en = 0;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      pw[k] = a_if.o_srf_p_data;
      if (k >= 3 && k <= 5) begin
        a_if.i_srf_start = 1; a_if.i_srf_p = 2; a_if.i_srf_q = 2;
      end else if (k == 15) begin
        a_if.i_srf_start = 1; a_if.i_srf_p = 1; a_if.i_srf_q = 3;
      end else begin
        a_if.i_srf_start = 0;
      end
      @(negedge clk);
    end
    a_if.i_srf_start = 0;
    chk("b2b_first_p", 32'(pw), 32'h0000);
    chk("b2b_busy", 32'(a_if.o_srf_busy), 32'd1);
    chk("b2b_beat0", 32'(a_if.o_srf_beat), 32'd0);
    for (int k = 0; k < 16; k++) begin
      pw[k] = a_if.o_srf_p_data;
      qw[k] = a_if.o_srf_q_data;
      @(negedge clk);
    end
    chk("b2b_second_p", 32'(pw), 32'hA5C3);
    chk("b2b_second_q", 32'(qw), 32'hFFFF);

    // constant register ignores writes
    xfer(0, 0, 1, 3, 16'h0000, pw, qw);
    xfer(3, 3, 0, 0, 16'h0000, pw, qw);
    chk("const_kept", 32'(pw), 32'hFFFF);

    // reset during beat 7 of a write of 0xFFFF to r0
    @(negedge clk);
    a_if.i_srf_start = 1; a_if.i_srf_p = 0; a_if.i_srf_q = 0;
    a_if.i_srf_wr_en = 1; a_if.i_srf_wr_idx = 0; a_if.i_srf_wr_data = 1;
    @(negedge clk);
    a_if.i_srf_start = 0;
    repeat (7) @(negedge clk);
    chk("pre_rst_beat", 32'(a_if.o_srf_beat), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(a_if.o_srf_busy), 32'd0);
    chk("rst_mid_beat", 32'(a_if.o_srf_beat), 32'd0);
    chk("rst_mid_last", 32'(a_if.o_srf_last), 32'd0);
    a_if.i_srf_wr_en = 0; a_if.i_srf_wr_data = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    xfer(0, 1, 0, 0, 16'h0000, pw, qw);
    chk("rst_r0", 32'(pw), 32'h0000);
    chk("rst_r1", 32'(qw), 32'h0000);

    // 5 x 8 instance: out-of-range and constant indices
    xfer_b(6, 5, 0, 0, 8'h00, pb, qb);
    chk("b_oor", 32'(pb), 32'h00);
    chk("b_const", 32'(qb), 32'hFF);
    xfer_b(0, 0, 1, 5, 8'h00, pb, qb);
    xfer_b(4, 5, 1, 4, 8'h3C, pb, qb);
    chk("b_r4_old", 32'(pb), 32'h00);
    chk("b_const_kept", 32'(qb), 32'hFF);
    xfer_b(4, 6, 0, 0, 8'h00, pb, qb);
    chk("b_r4_new", 32'(pb), 32'h3C);
    chk("b_oor2", 32'(qb), 32'h00);

    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/idli_srf_m.md
Name: idli_srf_m

Overview:
Parametrised bit-serial register file, successor to the 1-bit predicate file. It holds NUM_REGS registers of WIDTH bits plus one read-only constant register. Two read ports and one write port stream data LSB-first, one bit per cycle, over a WIDTH-beat transfer sequenced by an internal beat counter. It sits between decode and the serial ALU in the idli bit-serial core.

Parameters:
NUM_REGS, 3, number of writable registers; index NUM_REGS is the constant register
WIDTH, 16, bits per register and beats per transfer; power of two, >= 2
CONST_VAL, all-ones (WIDTH bits), value read from the constant register
IDXW, $clog2(NUM_REGS+1), index width (derived, not overridden)

Ports:
i_srf_gck  in  1  gated clock, all state on rising edge
i_srf_rst_n  in  1  asynchronous active-low reset
i_srf_start  in  1  request a transfer; sampled when idle or on the last beat
i_srf_p  in  IDXW  read port P register index, captured on accepted start
i_srf_q  in  IDXW  read port Q register index, captured on accepted start
i_srf_wr_en  in  1  transfer writes register i_srf_wr_idx, captured on accepted start
i_srf_wr_idx  in  IDXW  write register index, captured on accepted start
i_srf_wr_data  in  1  write bit for the current beat, sampled every active beat
o_srf_p_data  out  1  port P bit for the current beat
o_srf_q_data  out  1  port Q bit for the current beat
o_srf_busy  out  1  transfer active; beats in progress
o_srf_beat  out  $clog2(WIDTH)  current beat index (bit position)
o_srf_last  out  1  busy and beat == WIDTH-1

Behaviour:
- Reset (async assert, sync release): all registers 0; beat 0; busy 0; captured indices 0; captured wr_en 0. All outputs are 0 during reset.
- States: IDLE (busy=0) and ACTIVE (busy=1).
- IDLE: start=1 captures p, q, wr_en, wr_idx. Next cycle enters ACTIVE with beat=0. start=0 keeps IDLE.
- ACTIVE: beat increments by 1 each cycle. At beat WIDTH-1:
  - start=1 captures new indices; next cycle is beat 0 of the new transfer (back-to-back, no bubble).
  - start=0 returns to IDLE; beat wraps to 0.
- start during ACTIVE before the last beat is ignored; captured values are unchanged.
- Read (combinational from captured index and beat), in ACTIVE only:
  - index < NUM_REGS: reg[idx][beat].
  - index == NUM_REGS: CONST_VAL[beat].
  - index > NUM_REGS: 0.
  - Data outputs are 0 in IDLE.
- Write: at each rising edge in ACTIVE, if captured wr_en and wr_idx < NUM_REGS, reg[wr_idx][beat] <= i_srf_wr_data. Writes to the constant or out-of-range indices are dropped.
- Read/write collision: same register on a read port and the write port in the same beat returns the old bit (write lands at the edge ending the beat). This makes in-place serial ops (rN = rN op rM) correct.
- P and Q may name the same register; both return the same bit.
- Bit order LSB-first: beat k carries bit k.
- Reset mid-transfer aborts the transfer. Bits already written stay written until the reset clears all registers to 0. Busy goes 0 immediately.
- Latency: start at cycle t gives bit 0 at cycle t+1 and the last bit at cycle t+WIDTH.

Test Plan:
- Reset then start with p=0, q=3, wr_en=0 (defaults) -> busy high for 16 cycles; P streams 0 x16; Q streams 1 x16; last high only on cycle 16; then busy=0.
- Write r1: start wr_en=1, wr_idx=1, wr_data = bits of 0xA5C3 LSB-first; then a second transfer reading p=1 -> P streams 0xA5C3 LSB-first; r0 and r2 still read 0.
- In-place increment: r2=0x00FF; transfer p=2, wr_idx=2, bench feeds serial p+1 -> P shows old 0x00FF each beat; a later read returns 0x0100.
- Back-to-back: start held on the last beat with new p=1 -> no idle cycle; beat goes 15 then 0; P switches to r1 bit 0; start pulses mid-transfer are ignored.
- Constant and out-of-range: wr_idx=3 with wr_data=0 -> constant still reads 0xFFFF. NUM_REGS=5, WIDTH=8: index 6 reads 0x00; index 5 reads 0xFF.
- Reset at beat 7 of a write of 0xFFFF to r0 -> busy=0 and r0=0 immediately; after release, r0 reads 0.
